// File: rtl/pd8_pkg.sv
// Shared types, code constants and the code-to-one-hot helper for the pd8 decoder.
package pd8_pkg;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_MAX  = 4'd8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_ZERO,
    CLS_LEGAL,
    CLS_ILLEGAL
  } code_cls_t;

  function automatic logic [7:0] code2onehot(input logic [3:0] code);
    if (code != CODE_NONE && code <= CODE_MAX)
      code2onehot = 8'd1 << (code - 4'd1);
    else
      code2onehot = 8'd0;
  endfunction

endpackage

// File: rtl/pd8_if.sv
// Code/strobe bundle from the encoder side plus the decoder's status outputs.
interface pd8_if #(parameter int CNT_W = 8);
  logic             code_vld;
  logic [3:0]       code;
  logic             err_clr;
  logic [7:0]       line;
  logic             active;
  logic             illegal;
  logic             illegal_sticky;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output code_vld, code, err_clr,
    input  line, active, illegal, illegal_sticky, evt_cnt
  );

  modport slave (
    input  code_vld, code, err_clr,
    output line, active, illegal, illegal_sticky, evt_cnt
  );
endinterface

// File: rtl/pd8_classify.sv
// Combinational classification of an incoming code (none/zero/legal/illegal) plus its one-hot.
// Zero latency; no backpressure, purely combinational.
module pd8_classify
  import pd8_pkg::*;
(
  input  logic       code_vld,
  input  logic [3:0] code,
  output code_cls_t  cls,
  output logic [7:0] onehot
);

  always_comb begin
    cls = CLS_NONE;
    if (code_vld) begin
      if (code == CODE_NONE)
        cls = CLS_ZERO;
      else if (code <= CODE_MAX)
        cls = CLS_LEGAL;
      else
        cls = CLS_ILLEGAL;
    end
  end

  assign onehot = code2onehot(code);

endmodule

// File: rtl/pd8.sv
// Registered 4-bit code to one-hot line decoder with release hold, illegal flags and event count.
// Latency 1 falling edge; no backpressure, a code is accepted on every valid cycle.
module pd8
  import pd8_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  pd8_if.slave bus
);

  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVT_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       line_q, line_d;
  logic [7:0]       hold_q, hold_d;
  logic             active_q, active_d;
  logic             illegal_q, illegal_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic             new_line;

  code_cls_t  cls;
  logic [7:0] onehot;

  pd8_classify u_classify (
    .code_vld (bus.code_vld),
    .code     (bus.code),
    .cls      (cls),
    .onehot   (onehot)
  );

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    hold_d   = hold_q;
    evt_d    = evt_q;
    new_line = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cls == CLS_LEGAL) begin
          line_d   = onehot;
          new_line = 1'b1;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cls == CLS_LEGAL) begin
          new_line = (onehot != line_q);
          line_d   = onehot;
        end else if (cls == CLS_ZERO) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        // Anything but a legal code lets the release timer keep running.
        if (cls == CLS_LEGAL) begin
          new_line = (onehot != line_q);
          line_d   = onehot;
          hold_d   = 8'd0;
          state_d  = ST_ACTIVE;
        end else if (hold_q == 8'd0) begin
          line_d  = 8'd0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 8'd0;
        hold_d  = 8'd0;
      end
    endcase

    if (new_line && evt_q != EVT_MAX)
      evt_d = evt_q + 1'b1;

    illegal_d = (cls == CLS_ILLEGAL);
    sticky_d  = illegal_d | (sticky_q & ~bus.err_clr);
    active_d  = |line_d;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      line_q    <= 8'd0;
      hold_q    <= 8'd0;
      active_q  <= 1'b0;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
      evt_q     <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      hold_q    <= hold_d;
      active_q  <= active_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
      evt_q     <= evt_d;
    end
  end

  assign bus.line           = line_q;
  assign bus.active         = active_q;
  assign bus.illegal        = illegal_q;
  assign bus.illegal_sticky = sticky_q;
  assign bus.evt_cnt        = evt_q;

endmodule

// File: doc/pd8.md
# pd8

Registered 4-bit-code-to-one-hot decoder: the receive end of the 8-line priority-encoder code (0 = none, 1..8 = line n, 9..15 illegal). Accepts codes under a valid strobe, drives one-hot `line[7:0]`, and stretches every deasserting line by a programmable hold time. Flags illegal codes and counts line-change events for debug readout. Sits downstream of the PE8 encoder on the same clock.

## Interface
- `HOLD_CYCLES`, 4, cycles a line stays asserted after code returns to 0; legal range 1..255
- `CNT_W`, 8, width of event counter

- `clk`  in  1  clock; all state updates on falling edge, matching the encoder
- `rst`  in  1  reset, synchronous, active-high, sampled on falling edge of `clk`
- `code_vld`  in  1  `code` valid this cycle
- `code`  in  4  0 = none, 1..8 = line n active, 9..15 illegal
- `err_clr`  in  1  clears `illegal_sticky`
- `line`  out  8  one-hot decoded line, bit n-1 for code n; all-zero when idle
- `active`  out  1  `line` nonzero
- `illegal`  out  1  one-cycle pulse: illegal code accepted
- `illegal_sticky`  out  1  set by any accepted illegal code, held until `err_clr`
- `evt_cnt`  out  `CNT_W`  count of accepted changes to a new nonzero line; saturating

## Operation
- Reset: state IDLE, `line`=0, `active`=0, `illegal`=0, `illegal_sticky`=0, `evt_cnt`=0, hold counter 0.
- Accepted code = `code` when `code_vld`=1, classified ZERO, LEGAL (1..8) or ILLEGAL.
- FSM states IDLE, ACTIVE, HOLD:
  - IDLE: LEGAL -> `line`=onehot(code), `evt_cnt`+1, go ACTIVE. ZERO/ILLEGAL/no valid -> stay.
  - ACTIVE: LEGAL same as current -> no change. LEGAL different -> `line` switches directly (no zero cycle), `evt_cnt`+1. ZERO -> go HOLD, hold counter = `HOLD_CYCLES`-1, `line` unchanged. ILLEGAL or `code_vld`=0 -> no change.
  - HOLD: LEGAL -> go ACTIVE with onehot(code); `evt_cnt`+1 only if code differs from held line. Otherwise: hold counter 0 -> `line`=0, go IDLE; else decrement. Hold counter runs regardless of `code_vld`.
- ILLEGAL in any state: `illegal`=1 for one cycle, `illegal_sticky`=1; never alters `line`, state or `evt_cnt`.
- `err_clr` and illegal code in same cycle: set wins.
- `evt_cnt` stops at 2^`CNT_W`-1; never wraps.
- `active` is registered equal to (`line` != 0).

## Timing
- Latency 1: code accepted at falling edge N appears on `line` after edge N.
- ZERO accepted at edge N: `line` held through edges N+1..N+`HOLD_CYCLES`-1, cleared at edge N+`HOLD_CYCLES`. `HOLD_CYCLES`=1 clears at N+1.
- `illegal` high exactly one cycle after the accepting edge.
- `rst` overrides all inputs, including mid-HOLD; outputs at reset values after the reset edge.
- No combinational path input to output.

## Structure
- Package `pd8_pkg`: state enum (IDLE, ACTIVE, HOLD), constants `CODE_NONE`=0, `CODE_MAX`=8, function `code2onehot(code)` returning 8 bits.
- Sub-module `pd8_classify` (combinational: ZERO/LEGAL/ILLEGAL and one-hot) is natural; FSM, hold counter, flags and counter live in `pd8`.

## Test plan
- Reset then code=3 vld -> `line`=8'h04, `active`=1, `evt_cnt`=1 one edge later; rst mid-HOLD -> all outputs 0 next edge.
- code 5 then code 8 back-to-back -> `line` 8'h10 then 8'h80, no zero cycle, `evt_cnt`=2.
- code 2 then code 0 with `HOLD_CYCLES`=4 -> `line`=8'h02 for 4 edges after the zero, then 0, state IDLE; code 2 again during HOLD -> `evt_cnt` unchanged.
- code 12 vld while `line`=8'h01 -> `illegal` one-cycle pulse, `illegal_sticky`=1, `line` stays 8'h01; `err_clr` same cycle as another illegal -> sticky stays 1; `err_clr` alone -> 0.
- `code_vld`=0 with code=7 in IDLE -> no change; `CNT_W`=2, alternate codes 1/2 six times -> `evt_cnt` saturates at 3.
